// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stall, redirect flush,
// dmem-busy freeze, saturating debug counters and a sticky memory-wait timeout.
module pipeline_hazard_controller #(
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned MAX_WAIT  = 255,
   parameter int unsigned HAZARD_EN = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs1_i,
   input  logic [4:0]       id_rs2_i,
   input  logic             id_uses_rs1_i,
   input  logic             id_uses_rs2_i,
   input  logic             ex_mem_read_i,
   input  logic [4:0]       ex_rd_i,
   input  logic             mem_redirect_i,
   input  logic             dmem_busy_i,
   output logic             pc_write_o,
   output logic             if_id_write_o,
   output logic             id_ex_bubble_o,
   output logic             if_id_flush_o,
   output logic             id_ex_flush_o,
   output logic             ex_mem_flush_o,
   output logic             pipe_freeze_o,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] stall_count_o,
   output logic [CNT_W-1:0] flush_count_o,
   output logic             timeout_o
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_STALL  = 2'd1,
      ST_FLUSH  = 2'd2,
      ST_FREEZE = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] flush_q, flush_d;
   logic [15:0]      wait_q, wait_d;
   logic             timeout_q, timeout_d;
   logic             lu;

   always_comb begin
      lu = (HAZARD_EN != 0) && ex_mem_read_i && (ex_rd_i != 5'd0) &&
           ((id_uses_rs1_i && (id_rs1_i == ex_rd_i)) ||
            (id_uses_rs2_i && (id_rs2_i == ex_rd_i)));
   end

   // Priority: reset purge > freeze > redirect > load-use > run
   always_comb begin
      state_d        = ST_RUN;
      pc_write_o     = 1'b1;
      if_id_write_o  = 1'b1;
      id_ex_bubble_o = 1'b0;
      if_id_flush_o  = 1'b0;
      id_ex_flush_o  = 1'b0;
      ex_mem_flush_o = 1'b0;
      pipe_freeze_o  = 1'b0;
      if (reset) begin
         if_id_flush_o  = 1'b1;
         id_ex_flush_o  = 1'b1;
         ex_mem_flush_o = 1'b1;
      end else if (dmem_busy_i) begin
         state_d       = ST_FREEZE;
         pc_write_o    = 1'b0;
         if_id_write_o = 1'b0;
         pipe_freeze_o = 1'b1;
      end else if (mem_redirect_i) begin
         state_d        = ST_FLUSH;
         if_id_flush_o  = 1'b1;
         id_ex_flush_o  = 1'b1;
         ex_mem_flush_o = 1'b1;
      end else if (lu) begin
         state_d        = ST_STALL;
         pc_write_o     = 1'b0;
         if_id_write_o  = 1'b0;
         id_ex_bubble_o = 1'b1;
      end
   end

   always_comb begin
      stall_d = stall_q;
      flush_d = flush_q;
      if (state_d == ST_STALL && stall_q != '1) stall_d = stall_q + CNT_W'(1);
      if (state_d == ST_FLUSH && flush_q != '1) flush_d = flush_q + CNT_W'(1);
      wait_d = '0;
      if (dmem_busy_i) wait_d = (wait_q != '1) ? wait_q + 16'd1 : wait_q;
      timeout_d = timeout_q | (dmem_busy_i && (wait_d == 16'(MAX_WAIT)));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_RUN;
         stall_q   <= '0;
         flush_q   <= '0;
         wait_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         stall_q   <= stall_d;
         flush_q   <= flush_d;
         wait_q    <= wait_d;
         timeout_q <= timeout_d;
      end
   end

   assign state_o       = state_q;
   assign stall_count_o = stall_q;
   assign flush_count_o = flush_q;
   assign timeout_o     = timeout_q;

endmodule
